// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, ALU function selects,
// bus source codes, controller states and the decoder's output record.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVAC = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_JUMP = 4'h5;
  localparam logic [3:0] OP_JMPZ = 4'h6;
  localparam logic [3:0] OP_JPNZ = 4'h7;
  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_INAC = 4'hA;
  localparam logic [3:0] OP_CLAC = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_NOT  = 4'hF;

  typedef enum logic [3:0] {
    ALUS_CLAC = 4'b0000,
    ALUS_ADD  = 4'b0001,
    ALUS_SUB  = 4'b0010,
    ALUS_INAC = 4'b0011,
    ALUS_AND  = 4'b0100,
    ALUS_OR   = 4'b0101,
    ALUS_NOT  = 4'b0110,
    ALUS_XOR  = 4'b0111,
    ALUS_PASS = 4'b1000,
    ALUS_IDLE = 4'b1111
  } alus_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_MEM  = 3'd1,
    BUS_PC   = 3'd2,
    BUS_R    = 3'd3,
    BUS_AC   = 3'd4
  } bus_sel_e;

  typedef enum logic [2:0] {
    ST_F1, ST_F2, ST_DEC, ST_A2, ST_EX, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    OC_NOP, OC_ALU, OC_MOVR, OC_MVAC, OC_MEM, OC_JUMP, OC_ILLEGAL
  } op_class_e;

  typedef enum logic [1:0] {
    JC_ALWAYS, JC_Z, JC_NZ
  } jump_cond_e;

  typedef struct packed {
    op_class_e  cls;
    alus_e      alus;
    logic       store;
    jump_cond_e cond;
  } decode_t;

  function automatic logic jump_taken(input jump_cond_e cond, input logic z);
    case (cond)
      JC_Z:    return z;
      JC_NZ:   return !z;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: classifies the IR contents and supplies the
// ALU function for register-to-accumulator operations.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  output decode_t    dec
);

  always_comb begin
    dec = '{cls: OC_ILLEGAL, alus: ALUS_IDLE, store: 1'b0, cond: JC_ALWAYS};
    if (ir[7:4] == 4'h0) begin
      case (ir[3:0])
        OP_NOP:  dec.cls = OC_NOP;
        OP_LDAC: dec.cls = OC_MEM;
        OP_STAC: begin dec.cls = OC_MEM;  dec.store = 1'b1; end
        OP_MVAC: dec.cls = OC_MVAC;
        OP_MOVR: begin dec.cls = OC_MOVR; dec.alus = ALUS_PASS; end
        OP_JUMP: dec.cls = OC_JUMP;
        OP_JMPZ: begin dec.cls = OC_JUMP; dec.cond = JC_Z;  end
        OP_JPNZ: begin dec.cls = OC_JUMP; dec.cond = JC_NZ; end
        OP_ADD:  begin dec.cls = OC_ALU;  dec.alus = ALUS_ADD;  end
        OP_SUB:  begin dec.cls = OC_ALU;  dec.alus = ALUS_SUB;  end
        OP_INAC: begin dec.cls = OC_ALU;  dec.alus = ALUS_INAC; end
        OP_CLAC: begin dec.cls = OC_ALU;  dec.alus = ALUS_CLAC; end
        OP_AND:  begin dec.cls = OC_ALU;  dec.alus = ALUS_AND;  end
        OP_OR:   begin dec.cls = OC_ALU;  dec.alus = ALUS_OR;   end
        OP_XOR:  begin dec.cls = OC_ALU;  dec.alus = ALUS_XOR;  end
        OP_NOT:  begin dec.cls = OC_ALU;  dec.alus = ALUS_NOT;  end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle controller for the accumulator CPU: fetch, decode, operand
// address fetch and execute, with a memory handshake of unbounded wait.
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir,
  input  logic       z,
  input  logic       mem_ack,
  output logic [3:0] alus,
  output logic       ac_ld,
  output logic       z_ld,
  output logic       r_ld,
  output logic       ir_ld,
  output logic       ar_ld,
  output logic       pc_ld,
  output logic       pc_inc,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [2:0] bus_sel,
  output logic       halted
);

  state_e     state, state_nxt;
  decode_t    dec;
  op_class_e  cls_q;
  jump_cond_e cond_q;
  logic       store_q;
  alus_e      alus_v;
  bus_sel_e   bus_v;

  cu_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_F1;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: no reset here: these are always rewritten in DEC before A2/EX read them.
  // Latching the class keeps EX's mem_rd/mem_wr choice off the ir input path.
  always_ff @(posedge clk) begin
    if (state == ST_DEC) begin
      cls_q   <= dec.cls;
      cond_q  <= dec.cond;
      store_q <= dec.store;
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt = state;
    alus_v    = ALUS_IDLE;
    bus_v     = BUS_NONE;
    ac_ld     = 1'b0;
    z_ld      = 1'b0;
    r_ld      = 1'b0;
    ir_ld     = 1'b0;
    ar_ld     = 1'b0;
    pc_ld     = 1'b0;
    pc_inc    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    halted    = 1'b0;

    // Outputs stay idle while reset is held, so a reset landing mid-access
    // drops the memory request at once.
    if (rst_n) begin
      case (state)
        ST_F1: begin
          bus_v     = BUS_PC;
          ar_ld     = 1'b1;
          state_nxt = ST_F2;
        end
        ST_F2: begin
          mem_rd = 1'b1;
          bus_v  = BUS_MEM;
          if (mem_ack) begin
            ir_ld     = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = ST_DEC;
          end
        end
        ST_DEC: begin
          state_nxt = ST_F1;
          case (dec.cls)
            OC_ALU, OC_MOVR: begin
              alus_v = dec.alus;
              bus_v  = BUS_R;
              ac_ld  = 1'b1;
              z_ld   = 1'b1;
            end
            OC_MVAC: begin
              bus_v = BUS_AC;
              r_ld  = 1'b1;
            end
            OC_MEM, OC_JUMP: begin
              bus_v     = BUS_PC;
              ar_ld     = 1'b1;
              state_nxt = ST_A2;
            end
            OC_ILLEGAL: state_nxt = ST_HALT;
            default: ;
          endcase
        end
        ST_A2: begin
          mem_rd = 1'b1;
          bus_v  = BUS_MEM;
          if (mem_ack) begin
            if (cls_q == OC_JUMP) begin
              pc_ld     = jump_taken(cond_q, z);
              pc_inc    = !jump_taken(cond_q, z);
              state_nxt = ST_F1;
            end else begin
              ar_ld     = 1'b1;
              pc_inc    = 1'b1;
              state_nxt = ST_EX;
            end
          end
        end
        ST_EX: begin
          if (store_q) begin
            mem_wr = 1'b1;
            bus_v  = BUS_AC;
          end else begin
            mem_rd = 1'b1;
            bus_v  = BUS_MEM;
            if (mem_ack) begin
              alus_v = ALUS_PASS;
              ac_ld  = 1'b1;
              z_ld   = 1'b1;
            end
          end
          if (mem_ack) state_nxt = ST_F1;
        end
        ST_HALT: halted = 1'b1;
        default: state_nxt = ST_F1;
      endcase
    end
  end

  assign alus    = alus_v;
  assign bus_sel = bus_v;

endmodule

// File: tb/tb_control_unit.sv
// Randomized instruction stream against an instruction-level model: expected
// per-instruction summaries are queued at issue and compared by a monitor.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ir = 8'h00;
  logic       z = 1'b0;
  logic       mem_ack = 1'b0;
  logic [3:0] alus;
  logic       ac_ld, z_ld, r_ld, ir_ld, ar_ld, pc_ld, pc_inc;
  logic       mem_rd, mem_wr;
  logic [2:0] bus_sel;
  logic       halted;

  control_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ir      (ir),
    .z       (z),
    .mem_ack (mem_ack),
    .alus    (alus),
    .ac_ld   (ac_ld),
    .z_ld    (z_ld),
    .r_ld    (r_ld),
    .ir_ld   (ir_ld),
    .ar_ld   (ar_ld),
    .pc_ld   (pc_ld),
    .pc_inc  (pc_inc),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .bus_sel (bus_sel),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ir;
    logic       z;
    int         df;
    int         da;
    int         de;
  } plan_t;

  // Everything observed from an instruction's F1 up to the next F1.
  typedef struct packed {
    logic [7:0] fetch_cyc;
    logic [7:0] exec_cyc;
    logic [7:0] ar_ld;
    logic [7:0] ir_ld;
    logic [7:0] pc_inc;
    logic [7:0] pc_ld;
    logic [7:0] ac_ld;
    logic [7:0] z_ld;
    logic [7:0] r_ld;
    logic [7:0] rd_cyc;
    logic [7:0] wr_cyc;
    logic [7:0] rd_bus_bad;
    logic [7:0] wr_bus_bad;
    logic [7:0] both_bad;
    logic [7:0] idle_bad;
    logic [3:0] ac_alus;
    logic [2:0] ld_bus;
    logic       halted;
  } rec_t;

  plan_t plan_q[$];
  rec_t  exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] alu_code(input logic [3:0] op);
    case (op)
      4'h4: return 4'h8;
      4'h8: return 4'h1;
      4'h9: return 4'h2;
      4'hA: return 4'h3;
      4'hB: return 4'h0;
      4'hC: return 4'h4;
      4'hD: return 4'h5;
      4'hE: return 4'h7;
      default: return 4'h6;
    endcase
  endfunction

  function automatic int accesses(input plan_t p);
    logic [3:0] op = p.ir[3:0];
    if (p.ir[7:4] != 4'h0) return 1;
    if (op == 4'h1 || op == 4'h2) return 3;
    if (op >= 4'h5 && op <= 4'h7) return 2;
    return 1;
  endfunction

  function automatic rec_t model(input plan_t p);
    rec_t       r = '0;
    logic [3:0] op = p.ir[3:0];
    logic       taken;
    r.fetch_cyc = 8'(p.df + 2);
    r.rd_cyc    = 8'(p.df + 1);
    r.ar_ld     = 8'd1;
    r.ir_ld     = 8'd1;
    r.pc_inc    = 8'd1;
    r.exec_cyc  = 8'd1;
    if (p.ir[7:4] != 4'h0) begin
      r.halted = 1'b1;
    end else if (op == 4'h3) begin
      r.r_ld   = 8'd1;
      r.ld_bus = 3'd4;
    end else if (op == 4'h4 || op >= 4'h8) begin
      r.ac_ld   = 8'd1;
      r.z_ld    = 8'd1;
      r.ld_bus  = 3'd3;
      r.ac_alus = alu_code(op);
    end else if (op != 4'h0) begin
      r.ar_ld    += 8'd1;
      r.rd_cyc   += 8'(p.da + 1);
      r.exec_cyc += 8'(p.da + 1);
      if (op >= 4'h5) begin
        taken = (op == 4'h5) || (op == 4'h6 && p.z) || (op == 4'h7 && !p.z);
        if (taken) r.pc_ld = 8'd1;
        else       r.pc_inc += 8'd1;
      end else begin
        r.ar_ld    += 8'd1;
        r.pc_inc   += 8'd1;
        r.exec_cyc += 8'(p.de + 1);
        if (op == 4'h1) begin
          r.rd_cyc += 8'(p.de + 1);
          r.ac_ld   = 8'd1;
          r.z_ld    = 8'd1;
          r.ld_bus  = 3'd1;
          r.ac_alus = 4'h8;
        end else begin
          r.wr_cyc = 8'(p.de + 1);
        end
      end
    end
    return r;
  endfunction

  task automatic add_plan(input logic [7:0] op, input logic zv, input int df, input int da, input int de);
    plan_t p;
    p.ir = op; p.z = zv; p.df = df; p.da = da; p.de = de;
    plan_q.push_back(p);
  endtask

  // Memory responder: acks each access after its planned wait and loads IR.
  initial begin
    plan_t cur_p;
    int    n_acc = 0, acc_idx = 0, wait_cnt = 0, dly;
    logic  load_ir = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        n_acc = 0; acc_idx = 0; wait_cnt = 0; load_ir = 1'b0; mem_ack = 1'b0;
        continue;
      end
      if (load_ir) begin
        ir = cur_p.ir;
        load_ir = 1'b0;
      end
      z = 1'($urandom_range(0, 1));
      if (mem_rd || mem_wr) begin
        if (acc_idx == n_acc) begin
          if (plan_q.size() == 0) begin
            mem_ack = 1'b0;
            continue;
          end
          cur_p = plan_q.pop_front();
          exp_q.push_back(model(cur_p));
          n_acc = accesses(cur_p);
          acc_idx = 0;
          wait_cnt = 0;
        end
        dly = (acc_idx == 0) ? cur_p.df : (acc_idx == 1) ? cur_p.da : cur_p.de;
        if (wait_cnt == dly) begin
          mem_ack = 1'b1;
          if (acc_idx == 0) load_ir = 1'b1;
          if (acc_idx == 1) z = cur_p.z;
          acc_idx++;
          wait_cnt = 0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic close_rec(input rec_t got);
    check("sb_nonempty", 128'(exp_q.size() != 0), 128'(1));
    if (exp_q.size() != 0) check("instr_summary", 128'(got), 128'(exp_q.pop_front()));
  endtask

  // Monitor: folds DUT activity into per-instruction records.
  initial begin
    rec_t cur = '0;
    int   phase = 0;
    logic is_f1;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        check("reset_idle",
              {alus, bus_sel, ac_ld, z_ld, r_ld, ir_ld, ar_ld, pc_ld, pc_inc, mem_rd, mem_wr, halted},
              {4'hF, 3'd0, 10'd0});
        exp_q.delete();
        phase = 0;
        continue;
      end
      if (phase == 2 && halted) begin
        cur.halted = 1'b1;
        close_rec(cur);
        phase = 3;
      end
      if (phase == 3) begin
        check("halt_quiet",
              {alus, bus_sel, ac_ld, z_ld, r_ld, ir_ld, ar_ld, pc_ld, pc_inc, mem_rd, mem_wr, halted},
              {4'hF, 3'd0, 9'd0, 1'b1});
        continue;
      end
      is_f1 = ar_ld && bus_sel == 3'd2 && !(phase == 2 && cur.exec_cyc == 8'd0);
      if (is_f1) begin
        if (phase == 2) close_rec(cur);
        cur = '0;
        phase = 1;
      end
      if (phase == 0) continue;
      cur.ar_ld  += 8'(ar_ld);
      cur.ir_ld  += 8'(ir_ld);
      cur.pc_inc += 8'(pc_inc);
      cur.pc_ld  += 8'(pc_ld);
      cur.ac_ld  += 8'(ac_ld);
      cur.z_ld   += 8'(z_ld);
      cur.r_ld   += 8'(r_ld);
      cur.rd_cyc += 8'(mem_rd);
      cur.wr_cyc += 8'(mem_wr);
      cur.rd_bus_bad += 8'(mem_rd && bus_sel != 3'd1);
      cur.wr_bus_bad += 8'(mem_wr && bus_sel != 3'd4);
      cur.both_bad   += 8'(mem_rd && mem_wr);
      cur.idle_bad   += 8'(!ac_ld && alus != 4'hF);
      if (ac_ld) cur.ac_alus = alus;
      if (ac_ld || r_ld) cur.ld_bus = bus_sel;
      if (phase == 1) begin
        cur.fetch_cyc++;
        if (ir_ld) phase = 2;
      end else begin
        cur.exec_cyc++;
      end
    end
  end

  initial begin
    int i;
    rst_n = 1'b0;
    add_plan(8'h08, 1'b0, 0, 0, 0);
    add_plan(8'h01, 1'b0, 1, 3, 0);
    add_plan(8'h06, 1'b1, 0, 0, 0);
    add_plan(8'h06, 1'b0, 0, 0, 0);
    add_plan(8'h02, 1'b0, 0, 0, 2);
    for (int k = 0; k < 200; k++)
      add_plan(8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
    add_plan(8'h20, 1'b0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("first_cycle_f1", {ar_ld, bus_sel, halted, mem_rd}, {1'b1, 3'd2, 1'b0, 1'b0});

    for (i = 0; i < 20000; i++) begin
      if (plan_q.size() == 0 && exp_q.size() == 0 && halted === 1'b1) break;
      @(negedge clk);
    end
    check("run_to_halt", {plan_q.size() == 0, exp_q.size() == 0, halted}, 3'b111);

    repeat (10) @(negedge clk);
    check("halt_held", {halted, exp_q.size() == 0}, 2'b11);

    add_plan(8'h08, 1'b0, 0, 0, 0);
    add_plan(8'h02, 1'b0, 0, 0, 40);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("halt_exit_f1", {halted, ar_ld, bus_sel}, {1'b0, 1'b1, 3'd2});

    for (i = 0; i < 200; i++) begin
      if (mem_wr === 1'b1) break;
      @(negedge clk);
    end
    check("stac_ex_reached", {mem_wr, mem_rd, bus_sel}, {1'b1, 1'b0, 3'd4});

    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_mid_ex", {mem_wr, mem_rd, pc_ld, ac_ld, ar_ld, bus_sel},
          {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2});

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
